// File: rtl/lstm_q_pkg.sv
// Shared quantization constants, mode encodings and the 8-bit clamp
// used by the LSTM bias/requant datapath blocks.
package lstm_q_pkg;

  typedef enum logic {
    MODE_SIGMOID = 1'b0,
    MODE_TANH    = 1'b1
  } mode_e;

  localparam int DEF_IN_W          = 32;
  localparam int DEF_OUT_W         = 8;
  localparam int DEF_ACC_W         = 48;
  localparam int DEF_SCALE_DATA    = 128;
  localparam int DEF_SCALE_W       = 128;
  localparam int DEF_SCALE_B       = 256;
  localparam int DEF_ZERO_B        = 0;
  localparam int DEF_SCALE_SIGMOID = 24;
  localparam int DEF_ZERO_SIGMOID  = 128;
  localparam int DEF_SCALE_TANH    = 48;
  localparam int DEF_ZERO_TANH     = 128;
  localparam int DEF_CNT_W         = 16;

  function automatic logic [7:0] sat8(
    input logic signed [DEF_ACC_W-1:0] u
  );
    logic [7:0] r;
    if (u < 0)
      r = 8'd0;
    else if (u > 48'sd255)
      r = 8'hff;
    else
      r = u[7:0];
    return r;
  endfunction

endpackage

// File: rtl/requant_scale.sv
// Combinational signed rescale y = x * num / DEN, truncating toward zero.
// Ports: x (value), num (runtime numerator), y (scaled result).
module requant_scale #(
  parameter int ACC_W = 48,
  parameter int DEN   = 16384
) (
  input  logic signed [ACC_W-1:0] x,
  input  logic signed [ACC_W-1:0] num,
  output logic signed [ACC_W-1:0] y
);

  localparam logic signed [ACC_W-1:0] D = ACC_W'(DEN);

  logic signed [ACC_W-1:0] p;

  assign p = x * num;
  // signed '/' truncates toward zero
  assign y = p / D;

endmodule

// File: rtl/bias_requant_pipe.sv
// Pipelined bias add / requantize: rescales and accumulates partial sums,
// adds bias and zero point on the last term, saturates to OUT_W bits.
// Ports: in_* (beat stream, valid/ready), out_* (result stream),
//        sat_cnt/sat_clr (sticky saturation event counter).
module bias_requant_pipe
  import lstm_q_pkg::*;
#(
  parameter int IN_W          = DEF_IN_W,
  parameter int OUT_W         = DEF_OUT_W,
  parameter int ACC_W         = DEF_ACC_W,
  parameter int SCALE_DATA    = DEF_SCALE_DATA,
  parameter int SCALE_W       = DEF_SCALE_W,
  parameter int SCALE_B       = DEF_SCALE_B,
  parameter int ZERO_B        = DEF_ZERO_B,
  parameter int SCALE_SIGMOID = DEF_SCALE_SIGMOID,
  parameter int ZERO_SIGMOID  = DEF_ZERO_SIGMOID,
  parameter int SCALE_TANH    = DEF_SCALE_TANH,
  parameter int ZERO_TANH     = DEF_ZERO_TANH,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_last,
  input  logic             in_mode,
  input  logic [7:0]       in_bias,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_mode,
  output logic [CNT_W-1:0] sat_cnt,
  input  logic             sat_clr
);

  localparam logic signed [ACC_W-1:0] S_SIG =
    ACC_W'(SCALE_SIGMOID);
  localparam logic signed [ACC_W-1:0] S_TANH =
    ACC_W'(SCALE_TANH);
  localparam logic signed [ACC_W-1:0] Z_SIG =
    ACC_W'(ZERO_SIGMOID);
  localparam logic signed [ACC_W-1:0] Z_TANH =
    ACC_W'(ZERO_TANH);
  localparam logic signed [ACC_W-1:0] Z_B =
    ACC_W'(ZERO_B);
  localparam logic signed [ACC_W-1:0] U_MAX =
    ACC_W'((1 << OUT_W) - 1);

  logic en;
  logic fire;

  assign en       = !(out_valid && !out_ready);
  assign in_ready = en;
  assign fire     = in_valid && en;

  // element tracking: mode is frozen on the first beat
  logic first_q;
  logic elem_mode_q;
  logic cur_mode;

  assign cur_mode = first_q ? in_mode : elem_mode_q;

  // stage 0: input capture
  logic            s0_valid;
  logic            s0_first;
  logic            s0_last;
  logic            s0_mode;
  logic [IN_W-1:0] s0_data;
  logic [7:0]      s0_bias;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first_q     <= 1'b1;
      elem_mode_q <= 1'b0;
      s0_valid    <= 1'b0;
      s0_first    <= 1'b0;
      s0_last     <= 1'b0;
      s0_mode     <= 1'b0;
      s0_data     <= '0;
      s0_bias     <= '0;
    end else if (en) begin
      s0_valid <= fire;
      if (fire) begin
        first_q     <= in_last;
        elem_mode_q <= cur_mode;
        s0_first    <= first_q;
        s0_last     <= in_last;
        s0_mode     <= cur_mode;
        s0_data     <= in_data;
        if (in_last)
          s0_bias <= in_bias;
      end
    end
  end

  // stage 1: rescale term and bias
  logic signed [ACC_W-1:0] s0_scale;
  logic signed [ACC_W-1:0] x_ext;
  logic signed [ACC_W-1:0] b_ext;
  logic signed [ACC_W-1:0] term;
  logic signed [ACC_W-1:0] bterm;

  assign s0_scale = (s0_mode == MODE_TANH) ? S_TANH : S_SIG;
  assign x_ext    = {{(ACC_W-IN_W){s0_data[IN_W-1]}}, s0_data};
  assign b_ext    = $signed({{(ACC_W-8){1'b0}}, s0_bias}) - Z_B;

  requant_scale #(
    .ACC_W (ACC_W),
    .DEN   (SCALE_W * SCALE_DATA)
  ) u_term (
    .x   (x_ext),
    .num (s0_scale),
    .y   (term)
  );

  requant_scale #(
    .ACC_W (ACC_W),
    .DEN   (SCALE_B)
  ) u_bias (
    .x   (b_ext),
    .num (s0_scale),
    .y   (bterm)
  );

  logic                    s1_valid;
  logic                    s1_first;
  logic                    s1_last;
  logic                    s1_mode;
  logic signed [ACC_W-1:0] s1_term;
  logic signed [ACC_W-1:0] s1_bterm;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_mode  <= 1'b0;
      s1_term  <= '0;
      s1_bterm <= '0;
    end else if (en) begin
      s1_valid <= s0_valid;
      s1_first <= s0_first;
      s1_last  <= s0_last;
      s1_mode  <= s0_mode;
      s1_term  <= term;
      s1_bterm <= bterm;
    end
  end

  // stage 2: accumulate; s2_valid marks a completed element
  logic                    s2_valid;
  logic                    s2_mode;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] s2_bterm;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_mode  <= 1'b0;
      acc      <= '0;
      s2_bterm <= '0;
    end else if (en) begin
      s2_valid <= s1_valid && s1_last;
      if (s1_valid) begin
        acc      <= (s1_first ? '0 : acc) + s1_term;
        s2_mode  <= s1_mode;
        s2_bterm <= s1_bterm;
      end
    end
  end

  // stage 3: bias + zero point, clamp, output register
  logic signed [ACC_W-1:0] u;
  logic [7:0]              clamped;
  logic                    sat;

  assign u       = acc + s2_bterm +
                   ((s2_mode == MODE_TANH) ? Z_TANH : Z_SIG);
  assign clamped = sat8(u);
  assign sat     = (u < 0) || (u > U_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_mode  <= 1'b0;
    end else if (en) begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        out_data <= OUT_W'(clamped);
        out_mode <= s2_mode;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      sat_cnt <= '0;
    else if (sat_clr)
      sat_cnt <= '0;
    else if (en && s2_valid && sat && !(&sat_cnt))
      sat_cnt <= sat_cnt + 1'b1;
  end

endmodule

// File: tb/tb_bias_requant_pipe.sv
// Randomized + directed bench for bias_requant_pipe with an
// arithmetic reference model and a per-cycle output checker.
module tb_bias_requant_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        in_last = 1'b0;
  logic        in_mode = 1'b0;
  logic [7:0]  in_bias = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [7:0]  out_data;
  logic        out_mode;
  logic [15:0] sat_cnt;
  logic        sat_clr = 1'b0;

  always #5 clk = ~clk;

  bias_requant_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_mode   (in_mode),
    .in_bias   (in_bias),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_mode  (out_mode),
    .sat_cnt   (sat_cnt),
    .sat_clr   (sat_clr)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input bit ok, input string nm,
                     input longint act, input longint exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // reference model state
  bit     m_first = 1'b1;
  bit     m_mode = 1'b0;
  longint m_acc = 0;
  int     m_last = -1;
  int     exp_sat = 0;
  int     q_data[$];
  bit     q_mode[$];

  function automatic void model_beat(int d, bit l, bit md, int b);
    longint s;
    longint uu;
    int c;
    if (m_first) begin
      m_mode = md;
      m_acc = 0;
    end
    s = m_mode ? 48 : 24;
    m_acc += (longint'(d) * s) / 16384;
    if (l) begin
      uu = m_acc + (longint'(b - 0) * s) / 256 + 128;
      c = (uu < 0) ? 0 : ((uu > 255) ? 255 : int'(uu));
      q_data.push_back(c);
      q_mode.push_back(m_mode);
      m_last = c;
      if (longint'(c) != uu && exp_sat != 65535)
        exp_sat++;
    end
    m_first = l;
  endfunction

  // compare process
  bit   took = 1'b0;
  bit   held = 1'b0;
  int   held_data = 0;
  bit   held_mode = 1'b0;
  int   n_out = 0;
  int   last_out = -1;
  bit   last_mode = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      took = 1'b0;
      held = 1'b0;
      m_first = 1'b1;
      m_acc = 0;
      exp_sat = 0;
      q_data.delete();
      q_mode.delete();
    end else begin
      took = in_valid && in_ready;
      if (took)
        model_beat($signed(in_data), in_last, in_mode, int'(in_bias));
      chk(in_ready == !(out_valid && !out_ready), "in_ready",
          in_ready, !(out_valid && !out_ready));
      if (held) begin
        chk(out_valid && out_data == held_data &&
            out_mode == held_mode, "hold_stable", out_data, held_data);
      end
      held = out_valid && !out_ready;
      held_data = out_data;
      held_mode = out_mode;
      if (out_valid && out_ready) begin
        if (q_data.size() == 0) begin
          chk(1'b0, "spurious_out", out_data, -1);
        end else begin
          chk(out_data == q_data[0], "out_data", out_data, q_data[0]);
          chk(out_mode == q_mode[0], "out_mode", out_mode, q_mode[0]);
          void'(q_data.pop_front());
          void'(q_mode.pop_front());
        end
        n_out++;
        last_out = out_data;
        last_mode = out_mode;
      end
    end
  end

  bit bp_rand = 1'b0;

  always @(posedge clk) begin
    if (bp_rand) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic beat(input int d, input bit l, input bit md,
                      input int b);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data = d;
    in_last = l;
    in_mode = md;
    in_bias = b[7:0];
    @(posedge clk);
    while (!took && n < 500) begin
      n++;
      @(posedge clk);
    end
    if (n >= 500)
      chk(1'b0, "beat_timeout", n, 0);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q_data.size() != 0 || out_valid) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(n < 300, "drain_timeout", n, 0);
  endtask

  task automatic one(input int d, input bit md, input int b,
                     input int exp, input string nm);
    beat(d, 1'b1, md, b);
    drain();
    chk(m_last == exp, {nm, "_model"}, m_last, exp);
    chk(last_out == exp, nm, last_out, exp);
  endtask

  initial begin
    int k;
    int nt;
    #1;
    chk(in_ready == 1'b1, "rst_in_ready", in_ready, 1);
    chk(out_valid == 1'b0, "rst_out_valid", out_valid, 0);
    chk(out_data == 8'd0, "rst_out_data", out_data, 0);
    chk(out_mode == 1'b0, "rst_out_mode", out_mode, 0);
    chk(sat_cnt == 16'd0, "rst_sat_cnt", sat_cnt, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // single term tanh, with latency measurement
    beat(16384, 1'b1, 1'b1, 0);
    k = 0;
    while (!out_valid && k < 10) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk(k == 3, "latency", k, 3);
    drain();
    chk(m_last == 176, "tanh1_model", m_last, 176);
    chk(last_out == 176, "tanh1", last_out, 176);
    chk(last_mode == 1'b1, "tanh1_mode", last_mode, 1);
    chk(sat_cnt == 16'd0, "tanh1_sat", sat_cnt, 0);

    one(16384, 1'b0, 0, 152, "sig1");
    chk(last_mode == 1'b0, "sig1_mode", last_mode, 0);

    // two terms, mode flip on second beat ignored
    beat(16384, 1'b0, 1'b1, 0);
    beat(16384, 1'b1, 1'b0, 0);
    drain();
    chk(last_out == 224, "two_term", last_out, 224);
    chk(last_mode == 1'b1, "two_term_mode", last_mode, 1);

    // saturation both ways
    one(-100000, 1'b1, 0, 0, "sat_lo");
    one(50000, 1'b1, 0, 255, "sat_hi");
    chk(exp_sat == 2, "sat_model", exp_sat, 2);
    chk(sat_cnt == 16'd2, "sat_cnt2", sat_cnt, 2);
    sat_clr = 1'b1;
    @(posedge clk);
    #1 sat_clr = 1'b0;
    exp_sat = 0;
    chk(sat_cnt == 16'd0, "sat_clr", sat_cnt, 0);

    one(0, 1'b1, 255, 175, "bias_only");

    // backpressure with a stream of 1-term elements
    fork
      begin
        for (int i = 0; i < 8; i++)
          beat(1000 * i - 3000, 1'b1, i[0], i * 30);
      end
      begin
        out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk(out_valid && !in_ready, "bp_in_ready", in_ready, 0);
        out_ready = 1'b1;
      end
    join
    drain();
    chk(q_data.size() == 0, "bp_queue", q_data.size(), 0);

    // reset in the middle of an element
    beat(50000, 1'b0, 1'b1, 0);
    rst = 1'b1;
    #1;
    chk(out_valid == 1'b0 && out_data == 8'd0 && out_mode == 1'b0,
        "midrst_out", out_data, 0);
    chk(sat_cnt == 16'd0 && in_ready, "midrst_cnt", sat_cnt, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    one(16384, 1'b1, 0, 176, "after_rst");

    // randomized stream with random backpressure
    bp_rand = 1'b1;
    for (int e = 0; e < 80; e++) begin
      nt = $urandom_range(1, 3);
      for (int t = 0; t < nt; t++)
        beat(int'($urandom_range(0, 120000)) - 60000, t == nt - 1,
             $urandom_range(0, 1), $urandom_range(0, 255));
    end
    bp_rand = 1'b0;
    @(posedge clk);
    #1 out_ready = 1'b1;
    drain();
    chk(sat_cnt == exp_sat, "rand_sat_cnt", sat_cnt, exp_sat);
    chk(q_data.size() == 0, "rand_queue", q_data.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
